// File: rtl/imem_loader.sv
// imem_loader: byte-stream program loader for the instruction memory.
// Assembles little-endian 16-bit words from a valid/ready byte stream,
// writes them from address 0 upward and releases the CPU reset only once
// a complete image is in place.
// Optional: define IMEM_LOADER_CHKSUM_EN to require a trailing 16-bit
// checksum (sum of all words mod 2^16) before the image is accepted.
module imem_loader #(
  parameter  int INSTR_WIDTH        = 16,
  parameter  int ROM_REGISTER_COUNT = 1024,
  localparam int ADDR_W             = $clog2(ROM_REGISTER_COUNT)
) (
  input  logic                   clk,
  input  logic                   resetN,
  input  logic                   start,
  input  logic                   byte_valid,
  input  logic [7:0]             byte_data,
  output logic                   byte_ready,
  output logic                   wr_en,
  output logic [ADDR_W-1:0]      wr_addr,
  output logic [INSTR_WIDTH-1:0] wr_data,
  output logic                   cpu_resetN,
  output logic                   busy,
  output logic                   done,
  output logic                   error,
  output logic [ADDR_W:0]        word_count
);

  localparam logic [3:0] IDLE    = 4'd0;
  localparam logic [3:0] LEN_LO  = 4'd1;
  localparam logic [3:0] LEN_HI  = 4'd2;
  localparam logic [3:0] DATA_LO = 4'd3;
  localparam logic [3:0] DATA_HI = 4'd4;
  localparam logic [3:0] DONE    = 4'd5;
  localparam logic [3:0] ERR     = 4'd6;
`ifdef IMEM_LOADER_CHKSUM_EN
  localparam logic [3:0] CHK_LO  = 4'd7;
  localparam logic [3:0] CHK_HI  = 4'd8;
`endif

  logic [3:0]  state;
  logic [15:0] len;
  logic [7:0]  lo_byte;
  logic        loading;
  logic        accept;
  logic [15:0] len_in;
  logic [15:0] word_in;
  logic        last_word;
`ifdef IMEM_LOADER_CHKSUM_EN
  logic [15:0] sum;
`endif

  // Every state that consumes stream bytes is also a busy state.
`ifdef IMEM_LOADER_CHKSUM_EN
  assign loading = (state == LEN_LO) | (state == LEN_HI) | (state == DATA_LO) |
                   (state == DATA_HI) | (state == CHK_LO) | (state == CHK_HI);
`else
  assign loading = (state == LEN_LO) | (state == LEN_HI) | (state == DATA_LO) |
                   (state == DATA_HI);
`endif
  assign byte_ready = loading;
  assign busy       = loading;
  assign accept     = byte_valid & byte_ready;
  assign len_in     = {byte_data, len[7:0]};
  assign word_in    = {byte_data, lo_byte};
  // word_count still holds the index of the word being completed
  assign last_word  = (16'(word_count) + 16'd1) == len;

  // Load sequencer; write port and status flags are registered so the
  // memory strobe and the CPU reset are glitch-free.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state      <= IDLE;
      len        <= '0;
      lo_byte    <= '0;
      wr_en      <= 1'b0;
      wr_addr    <= '0;
      wr_data    <= '0;
      cpu_resetN <= 1'b0;
      done       <= 1'b0;
      error      <= 1'b0;
      word_count <= '0;
`ifdef IMEM_LOADER_CHKSUM_EN
      sum        <= '0;
`endif
    end else begin
      wr_en <= 1'b0;
      case (state)
        IDLE, DONE, ERR: if (start) begin
          state      <= LEN_LO;
          cpu_resetN <= 1'b0;
          done       <= 1'b0;
          error      <= 1'b0;
          word_count <= '0;
`ifdef IMEM_LOADER_CHKSUM_EN
          sum        <= '0;
`endif
        end
        LEN_LO: if (accept) begin
          len[7:0] <= byte_data;
          state    <= LEN_HI;
        end
        LEN_HI: if (accept) begin
          len[15:8] <= byte_data;
          if (len_in == 16'd0) begin
`ifdef IMEM_LOADER_CHKSUM_EN
            state <= CHK_LO;
`else
            state      <= DONE;
            done       <= 1'b1;
            cpu_resetN <= 1'b1;
`endif
          end else if (len_in > 16'(ROM_REGISTER_COUNT)) begin
            state <= ERR;
            error <= 1'b1;
          end else begin
            state <= DATA_LO;
          end
        end
        DATA_LO: if (accept) begin
          lo_byte <= byte_data;
          state   <= DATA_HI;
        end
        // Write lands the cycle after the high byte; N is bounded, so the
        // index can never wrap.
        DATA_HI: if (accept) begin
          wr_en      <= 1'b1;
          wr_addr    <= word_count[ADDR_W-1:0];
          wr_data    <= word_in;
          word_count <= word_count + 1'b1;
`ifdef IMEM_LOADER_CHKSUM_EN
          sum        <= sum + word_in;
          state      <= last_word ? CHK_LO : DATA_LO;
`else
          if (last_word) begin
            state      <= DONE;
            done       <= 1'b1;
            cpu_resetN <= 1'b1;
          end else begin
            state <= DATA_LO;
          end
`endif
        end
`ifdef IMEM_LOADER_CHKSUM_EN
        CHK_LO: if (accept) begin
          lo_byte <= byte_data;
          state   <= CHK_HI;
        end
        CHK_HI: if (accept) begin
          if (word_in == sum) begin
            state      <= DONE;
            done       <= 1'b1;
            cpu_resetN <= 1'b1;
          end else begin
            state <= ERR;
            error <= 1'b1;
          end
        end
`endif
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: directed self-checking bench for imem_loader.
// Checksum scenarios are compiled in when IMEM_LOADER_CHKSUM_EN is defined.
module tb_imem_loader;
  localparam int ADDR_W = 10;

  logic              clk = 1'b0;
  logic              resetN, start, byte_valid;
  logic [7:0]        byte_data;
  logic              byte_ready, wr_en, cpu_resetN, busy, done, error;
  logic [ADDR_W-1:0] wr_addr;
  logic [15:0]       wr_data;
  logic [ADDR_W:0]   word_count;

  int vectors = 0, miscompares = 0, cyc = 0, cur_n = 0;
  logic [15:0] img [0:1023];
  int          hi_acc [0:1023];
  logic [ADDR_W-1:0] wq_addr [$];
  logic [15:0]       wq_data [$];
  int                wq_cyc  [$];

  imem_loader dut (
    .clk(clk), .resetN(resetN), .start(start), .byte_valid(byte_valid),
    .byte_data(byte_data), .byte_ready(byte_ready), .wr_en(wr_en),
    .wr_addr(wr_addr), .wr_data(wr_data), .cpu_resetN(cpu_resetN),
    .busy(busy), .done(done), .error(error), .word_count(word_count)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // capture every memory write with the cycle it appeared in
  always @(negedge clk) if (wr_en === 1'b1) begin
    wq_addr.push_back(wr_addr);
    wq_data.push_back(wr_data);
    wq_cyc.push_back(cyc);
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: run did not complete, vectors=%0d", vectors);
    $fatal(1);
  end

  // all stimulus tasks start and end on a falling edge
  task automatic send_byte(input logic [7:0] b, input int gap, output int acc);
    int n;
    n = 0;
    if (gap > 0) begin
      byte_valid = 1'b0;
      repeat (gap) @(negedge clk);
    end
    byte_valid = 1'b1;
    byte_data  = b;
    while (byte_ready !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) begin
      $display("FAIL accept_timeout byte=%h ready=%b want 1", b, byte_ready);
      miscompares++; vectors++;
      acc = -1;
    end else begin
      @(negedge clk);
      acc = cyc;
    end
  endtask

  task automatic pulse_start();
    wq_addr.delete(); wq_data.delete(); wq_cyc.delete();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic send_image(input int n, input bit gapped);
    int a;
    logic [15:0] nn;
    nn = 16'(n);
    cur_n = n;
    send_byte(nn[7:0], 0, a);
    send_byte(nn[15:8], 0, a);
    for (int i = 0; i < n; i++) begin
      send_byte(img[i][7:0], gapped ? int'($urandom_range(0, 2)) : 0, a);
      send_byte(img[i][15:8], gapped ? 2 : 0, hi_acc[i]);
    end
  endtask

  task automatic finish_stream();
`ifdef IMEM_LOADER_CHKSUM_EN
    logic [15:0] s;
    int a;
    s = 16'h0;
    for (int i = 0; i < cur_n; i++) s = s + img[i];
    send_byte(s[7:0], 0, a);
    send_byte(s[15:8], 0, a);
`endif
    byte_valid = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_reset();
    vectors++;
    if ({byte_ready, wr_en, busy, done, error, cpu_resetN} !== 6'b0) begin
      $display("FAIL reset_flags got %b want 000000", {byte_ready, wr_en, busy, done, error, cpu_resetN});
      miscompares++;
    end
    vectors++;
    if (wr_addr !== '0) begin $display("FAIL reset_wr_addr got %h want 0", wr_addr); miscompares++; end
    vectors++;
    if (wr_data !== '0) begin $display("FAIL reset_wr_data got %h want 0", wr_data); miscompares++; end
    vectors++;
    if (word_count !== '0) begin $display("FAIL reset_word_count got %0d want 0", word_count); miscompares++; end
  endtask

  task automatic test_basic();
    img[0] = 16'h1234; img[1] = 16'h5678; img[2] = 16'h9ABC;
    pulse_start();
    vectors++;
    if ({busy, byte_ready, cpu_resetN} !== 3'b110) begin
      $display("FAIL basic_start got %b want 110", {busy, byte_ready, cpu_resetN}); miscompares++;
    end
    send_image(3, 1'b0);
    finish_stream();
    vectors++;
    if (wq_addr.size() !== 3) begin $display("FAIL basic_nwrites got %0d want 3", wq_addr.size()); miscompares++; end
    for (int i = 0; i < 3 && i < wq_addr.size(); i++) begin
      vectors++;
      if (wq_addr[i] !== ADDR_W'(i) || wq_data[i] !== img[i]) begin
        $display("FAIL basic_write%0d got %0d:%h want %0d:%h", i, wq_addr[i], wq_data[i], i, img[i]); miscompares++;
      end
      vectors++;
      if (wq_cyc[i] !== hi_acc[i]) begin
        $display("FAIL basic_latency%0d got cycle %0d want %0d", i, wq_cyc[i], hi_acc[i]); miscompares++;
      end
    end
    vectors++;
    if ({done, cpu_resetN, busy, error} !== 4'b1100) begin
      $display("FAIL basic_status got %b want 1100", {done, cpu_resetN, busy, error}); miscompares++;
    end
    vectors++;
    if (word_count !== 11'd3) begin $display("FAIL basic_word_count got %0d want 3", word_count); miscompares++; end
  endtask

  task automatic test_zero_len();
    int a;
    pulse_start();
    cur_n = 0;
    send_byte(8'h00, 0, a);
    send_byte(8'h00, 0, a);
    finish_stream();
    vectors++;
    if (wq_addr.size() !== 0) begin $display("FAIL zero_nwrites got %0d want 0", wq_addr.size()); miscompares++; end
    vectors++;
    if ({done, cpu_resetN, error} !== 3'b110) begin
      $display("FAIL zero_status got %b want 110", {done, cpu_resetN, error}); miscompares++;
    end
    vectors++;
    if (word_count !== '0) begin $display("FAIL zero_word_count got %0d want 0", word_count); miscompares++; end
`ifdef IMEM_LOADER_CHKSUM_EN
    pulse_start();
    send_byte(8'h00, 0, a);
    send_byte(8'h00, 0, a);
    send_byte(8'h01, 0, a);
    send_byte(8'h00, 0, a);
    byte_valid = 1'b0;
    repeat (3) @(negedge clk);
    vectors++;
    if ({done, error, cpu_resetN} !== 3'b010) begin
      $display("FAIL zero_badchk got %b want 010", {done, error, cpu_resetN}); miscompares++;
    end
`endif
  endtask

  task automatic test_too_long();
    int a;
    pulse_start();
    send_byte(8'h01, 0, a);
    send_byte(8'h04, 0, a);
    byte_valid = 1'b0;
    repeat (3) @(negedge clk);
    vectors++;
    if ({error, done, cpu_resetN, busy, byte_ready} !== 5'b10000) begin
      $display("FAIL toolong_status got %b want 10000", {error, done, cpu_resetN, busy, byte_ready}); miscompares++;
    end
    vectors++;
    if (wq_addr.size() !== 0) begin $display("FAIL toolong_nwrites got %0d want 0", wq_addr.size()); miscompares++; end
    img[0] = 16'hA55A;
    pulse_start();
    vectors++;
    if ({error, busy} !== 2'b01) begin $display("FAIL toolong_restart got %b want 01", {error, busy}); miscompares++; end
    send_image(1, 1'b0);
    finish_stream();
    vectors++;
    if (wq_addr.size() !== 1 || wq_addr[0] !== '0 || wq_data[0] !== 16'hA55A) begin
      $display("FAIL toolong_reload got n=%0d %0d:%h want n=1 0:a55a", wq_addr.size(), wq_addr[0], wq_data[0]); miscompares++;
    end
    vectors++;
    if ({done, error, cpu_resetN} !== 3'b101) begin
      $display("FAIL toolong_reload_status got %b want 101", {done, error, cpu_resetN}); miscompares++;
    end
  endtask

  task automatic test_gapped();
    img[0] = 16'h0F01; img[1] = 16'h1E02; img[2] = 16'h2D03; img[3] = 16'h3C04;
    pulse_start();
    send_image(4, 1'b1);
    finish_stream();
    vectors++;
    if (wq_addr.size() !== 4) begin $display("FAIL gapped_nwrites got %0d want 4", wq_addr.size()); miscompares++; end
    for (int i = 0; i < 4 && i < wq_addr.size(); i++) begin
      vectors++;
      if (wq_addr[i] !== ADDR_W'(i) || wq_data[i] !== img[i] || wq_cyc[i] !== hi_acc[i]) begin
        $display("FAIL gapped_write%0d got %0d:%h@%0d want %0d:%h@%0d", i, wq_addr[i], wq_data[i], wq_cyc[i], i, img[i], hi_acc[i]);
        miscompares++;
      end
    end
    vectors++;
    if ({done, word_count} !== {1'b1, 11'd4}) begin
      $display("FAIL gapped_status got done=%b count=%0d want done=1 count=4", done, word_count); miscompares++;
    end
  endtask

  task automatic test_start_while_busy();
    int a;
    img[0] = 16'hBEEF; img[1] = 16'hCAFE;
    pulse_start();
    cur_n = 2;
    send_byte(8'h02, 0, a);
    send_byte(8'h00, 0, a);
    send_byte(8'hEF, 0, a);
    byte_valid = 1'b0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    send_byte(8'hBE, 0, a);
    send_byte(8'hFE, 0, a);
    send_byte(8'hCA, 0, a);
    finish_stream();
    vectors++;
    if (wq_addr.size() !== 2) begin $display("FAIL busystart_nwrites got %0d want 2", wq_addr.size()); miscompares++; end
    for (int i = 0; i < 2 && i < wq_addr.size(); i++) begin
      vectors++;
      if (wq_addr[i] !== ADDR_W'(i) || wq_data[i] !== img[i]) begin
        $display("FAIL busystart_write%0d got %0d:%h want %0d:%h", i, wq_addr[i], wq_data[i], i, img[i]); miscompares++;
      end
    end
    vectors++;
    if ({done, word_count} !== {1'b1, 11'd2}) begin
      $display("FAIL busystart_status got done=%b count=%0d want done=1 count=2", done, word_count); miscompares++;
    end
  endtask

  task automatic test_done_ignores_bytes();
    int n0;
    n0 = wq_addr.size();
    byte_valid = 1'b1;
    byte_data  = 8'h55;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      vectors++;
      if (byte_ready !== 1'b0) begin $display("FAIL done_ready%0d got %b want 0", i, byte_ready); miscompares++; end
    end
    byte_valid = 1'b0;
    vectors++;
    if (wq_addr.size() !== n0 || word_count !== 11'd2 || done !== 1'b1) begin
      $display("FAIL done_idle got n=%0d count=%0d done=%b want n=%0d count=2 done=1", wq_addr.size(), word_count, done, n0);
      miscompares++;
    end
  endtask

  task automatic test_reset_midload();
    int a;
    for (int i = 0; i < 5; i++) img[i] = 16'h1111 * 16'(i + 1);
    pulse_start();
    cur_n = 5;
    send_byte(8'h05, 0, a);
    send_byte(8'h00, 0, a);
    for (int i = 0; i < 2; i++) begin
      send_byte(img[i][7:0], 0, a);
      send_byte(img[i][15:8], 0, a);
    end
    byte_valid = 1'b0;
    @(negedge clk);
    vectors++;
    if ({busy, word_count} !== {1'b1, 11'd2}) begin
      $display("FAIL midload_pre got busy=%b count=%0d want busy=1 count=2", busy, word_count); miscompares++;
    end
    #2 resetN = 1'b0;
    #1;
    vectors++;
    if ({byte_ready, wr_en, busy, done, error, cpu_resetN} !== 6'b0 || word_count !== '0 ||
        wr_addr !== '0 || wr_data !== '0) begin
      $display("FAIL midload_reset got flags=%b count=%0d addr=%0d data=%h want all 0",
               {byte_ready, wr_en, busy, done, error, cpu_resetN}, word_count, wr_addr, wr_data);
      miscompares++;
    end
    @(negedge clk);
    resetN = 1'b1;
    @(negedge clk);
    pulse_start();
    send_image(5, 1'b0);
    finish_stream();
    vectors++;
    if (wq_addr.size() !== 5) begin $display("FAIL midload_nwrites got %0d want 5", wq_addr.size()); miscompares++; end
    for (int i = 0; i < 5 && i < wq_addr.size(); i++) begin
      vectors++;
      if (wq_addr[i] !== ADDR_W'(i) || wq_data[i] !== img[i]) begin
        $display("FAIL midload_write%0d got %0d:%h want %0d:%h", i, wq_addr[i], wq_data[i], i, img[i]); miscompares++;
      end
    end
    vectors++;
    if ({done, cpu_resetN, word_count} !== {2'b11, 11'd5}) begin
      $display("FAIL midload_status got done=%b cpu=%b count=%0d want 1 1 5", done, cpu_resetN, word_count); miscompares++;
    end
  endtask

  task automatic test_full_depth();
    int bad;
    bad = 0;
    for (int i = 0; i < 1024; i++) img[i] = 16'(i * 7 + 3);
    pulse_start();
    send_image(1024, 1'b0);
    finish_stream();
    vectors++;
    if (wq_addr.size() !== 1024) begin $display("FAIL full_nwrites got %0d want 1024", wq_addr.size()); miscompares++; end
    for (int i = 0; i < 1024 && i < wq_addr.size(); i++) begin
      vectors++;
      if (wq_addr[i] !== ADDR_W'(i) || wq_data[i] !== img[i]) begin
        if (bad < 8) $display("FAIL full_write%0d got %0d:%h want %0d:%h", i, wq_addr[i], wq_data[i], i, img[i]);
        bad++;
        miscompares++;
      end
    end
    vectors++;
    if ({done, error, cpu_resetN, word_count} !== {3'b101, 11'd1024}) begin
      $display("FAIL full_status got done=%b err=%b cpu=%b count=%0d want 1 0 1 1024", done, error, cpu_resetN, word_count);
      miscompares++;
    end
  endtask

`ifdef IMEM_LOADER_CHKSUM_EN
  task automatic test_checksum();
    int a;
    img[0] = 16'hFFFF; img[1] = 16'h0002;
    pulse_start();
    send_image(2, 1'b0);
    send_byte(8'h01, 0, a);
    send_byte(8'h00, 0, a);
    byte_valid = 1'b0;
    repeat (3) @(negedge clk);
    vectors++;
    if ({done, error, cpu_resetN} !== 3'b101 || wq_addr.size() !== 2) begin
      $display("FAIL chk_wrap_good got %b n=%0d want 101 n=2", {done, error, cpu_resetN}, wq_addr.size()); miscompares++;
    end
    pulse_start();
    send_image(2, 1'b0);
    send_byte(8'h02, 0, a);
    send_byte(8'h00, 0, a);
    byte_valid = 1'b0;
    repeat (3) @(negedge clk);
    vectors++;
    if ({done, error, cpu_resetN} !== 3'b010 || wq_addr.size() !== 2) begin
      $display("FAIL chk_wrap_bad got %b n=%0d want 010 n=2", {done, error, cpu_resetN}, wq_addr.size()); miscompares++;
    end
  endtask
`endif

  initial begin
    resetN = 1'b0; start = 1'b0; byte_valid = 1'b0; byte_data = 8'h00;
    repeat (2) @(negedge clk);
    test_reset();
    resetN = 1'b1;
    @(negedge clk);
    test_basic();
    test_zero_len();
    test_too_long();
    test_gapped();
    test_start_while_busy();
    test_done_ignores_bytes();
    test_reset_midload();
    test_full_depth();
`ifdef IMEM_LOADER_CHKSUM_EN
    test_checksum();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
